// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Constants and types shared by the sprite blitter and its bench:
//   COLOUR_W        colour width (3:3:3)
//   X_W / Y_W       screen coordinate widths
//   SCREEN_W/H      visible screen size used for clipping
//   TRANSPARENT_KEY default colour key that is never plotted in draw mode
//   state_t         blitter sequencing states
// -----------------------------------------------------------------------------
package draw_pkg;

   localparam int COLOUR_W = 9;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [COLOUR_W-1:0] TRANSPARENT_KEY = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/sprite_pixel_counter.sv
// -----------------------------------------------------------------------------
// sprite_pixel_counter
// Raster-order column/row counter over an SPR_W x SPR_H sprite.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   clear        return to (0,0); has priority over enable
//   enable       advance one pixel, col wraps to 0 and row increments
//   col, row     current pixel position
//   last         high while positioned on (SPR_W-1, SPR_H-1)
// -----------------------------------------------------------------------------
module sprite_pixel_counter #(
   parameter  int SPR_W = 20,
   parameter  int SPR_H = 20,
   localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1,
   localparam int RW    = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);

   logic col_end;
   logic row_end;

   assign col_end = (col == COL_MAX);
   assign row_end = (row == ROW_MAX);
   assign last    = col_end && row_end;

   // Column/row position register with wrap at the sprite edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (enable) begin
         if (col_end) begin
            col <= '0;
            if (row_end) begin
               row <= '0;
            end else begin
               row <= row + RW'(1);
            end
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/draw_sprite.sv
// -----------------------------------------------------------------------------
// draw_sprite
// Sprite blitter: walks one SPR_W x SPR_H sprite out of a synchronous ROM and
// emits one pixel per cycle to the VGA adapter, with colour-key transparency,
// screen-edge clipping and an erase (background fill) mode.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   start            begin a blit (only honoured while idle)
//   abort            cancel a running blit, no done pulse
//   erase            0 = copy sprite, 1 = fill footprint with bg_colour
//   sprite_id        which sprite of the ROM bank
//   base_x, base_y   top-left screen position
//   bg_colour        fill colour for erase mode
//   rom_addr         registered ROM address
//   rom_q            ROM data, one cycle after rom_addr
//   x, y, colour     pixel to VGA (registered)
//   plot             VGA write enable (registered)
//   busy             blit in progress
//   done             one-cycle pulse on normal completion
// Pixel k: address in cycle k+1, ROM data in k+2, on the VGA port in k+3.
// -----------------------------------------------------------------------------
module draw_sprite #(
   parameter  int SPR_W    = 20,
   parameter  int SPR_H    = 20,
   parameter  int NUM_SPR  = 4,
   parameter  int COLOUR_W = draw_pkg::COLOUR_W,
   parameter  int X_W      = draw_pkg::X_W,
   parameter  int Y_W      = draw_pkg::Y_W,
   parameter  int SCREEN_W = draw_pkg::SCREEN_W,
   parameter  int SCREEN_H = draw_pkg::SCREEN_H,
   parameter  logic [COLOUR_W-1:0] TRANSPARENT = draw_pkg::TRANSPARENT_KEY,
   localparam int SID_W    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
   localparam int AW       = $clog2(NUM_SPR * SPR_W * SPR_H)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                abort,
   input  logic                erase,
   input  logic [SID_W-1:0]    sprite_id,
   input  logic [X_W-1:0]      base_x,
   input  logic [Y_W-1:0]      base_y,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic [AW-1:0]       rom_addr,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   import draw_pkg::state_t;
   import draw_pkg::IDLE;
   import draw_pkg::RUN;
   import draw_pkg::FLUSH;

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   localparam logic [AW-1:0]  SPR_SIZE = AW'(SPR_W * SPR_H);
   localparam logic [X_W:0]   X_LIMIT  = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0]   Y_LIMIT  = (Y_W + 1)'(SCREEN_H);

   state_t state;
   state_t next_state;

   logic load;          // start accepted this cycle
   logic cnt_clear;
   logic cnt_en;
   logic finish;        // normal end of FLUSH
   logic kill;          // abort while a blit is active
   logic flush_second;  // set during the second FLUSH cycle

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last;

   logic                erase_l;
   logic [X_W-1:0]      base_x_l;
   logic [Y_W-1:0]      base_y_l;
   logic [COLOUR_W-1:0] bg_l;

   logic          s1_valid;
   logic [CW-1:0] s1_col;
   logic [RW-1:0] s1_row;

   logic [X_W:0]        x_sum;
   logic [Y_W:0]        y_sum;
   logic [COLOUR_W-1:0] pix_colour;
   logic                visible;

   sprite_pixel_counter #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and sequencing controls.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
      finish     = 1'b0;
      kill       = 1'b0;
      case (state)
         IDLE: begin
            // abort is ignored here, so start+abort together starts a blit
            if (start) begin
               next_state = RUN;
               load       = 1'b1;
               cnt_clear  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               next_state = IDLE;
               kill       = 1'b1;
            end else if (last) begin
               next_state = FLUSH;
            end else begin
               next_state = RUN;
               cnt_en     = 1'b1;
            end
         end
         FLUSH: begin
            if (abort) begin
               next_state = IDLE;
               kill       = 1'b1;
            end else if (flush_second) begin
               next_state = IDLE;
               finish     = 1'b1;
            end else begin
               next_state = FLUSH;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Two-cycle FLUSH timer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         flush_second <= 1'b0;
      end else begin
         flush_second <= (state == FLUSH) && (next_state == FLUSH);
      end
   end

   // Blit parameters are captured once at start and held for the whole blit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         erase_l  <= 1'b0;
         base_x_l <= '0;
         base_y_l <= '0;
         bg_l     <= '0;
      end else if (load) begin
         erase_l  <= erase;
         base_x_l <= base_x;
         base_y_l <= base_y;
         bg_l     <= bg_colour;
      end
   end

   // ROM address: sprites are contiguous and walked in raster order, so
   // sprite_id*N + row*SPR_W + col is simply an increment from the sprite base.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rom_addr <= '0;
      end else if (load) begin
         rom_addr <= AW'(sprite_id) * SPR_SIZE;
      end else if (cnt_en) begin
         rom_addr <= rom_addr + AW'(1);
      end
   end

   // Pipeline stage aligning col/row with the ROM read latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         s1_valid <= (state == RUN) && !abort;
         s1_col   <= col;
         s1_row   <= row;
      end
   end

   // Screen position one bit wider so off-screen pixels clip instead of wrapping.
   always_comb begin
      x_sum = {1'b0, base_x_l} + (X_W + 1)'(s1_col);
      y_sum = {1'b0, base_y_l} + (Y_W + 1)'(s1_row);
      if (erase_l) begin
         pix_colour = bg_l;
      end else begin
         pix_colour = rom_q;
      end
      visible = s1_valid && (x_sum < X_LIMIT) && (y_sum < Y_LIMIT) &&
                (erase_l || (rom_q != TRANSPARENT));
   end

   // Registered VGA pixel port and handshake outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         x      <= x_sum[X_W-1:0];
         y      <= y_sum[Y_W-1:0];
         colour <= pix_colour;
         plot   <= visible && !kill;
         busy   <= (next_state != IDLE);
         done   <= finish;
      end
   end

endmodule

// File: tb/tb_draw_sprite.sv
// -----------------------------------------------------------------------------
// tb_draw_sprite
// Directed bench for draw_sprite: a table of blits with hand-computed
// first/last plot positions, plot counts and done timing, a per-cycle pixel
// model against a bench-owned ROM image, and hand-written sequences for
// re-start, abort, start+abort and reset in the middle of a blit.
// -----------------------------------------------------------------------------
module tb_draw_sprite;
   import draw_pkg::*;

   localparam int SPR_W   = 20;
   localparam int SPR_H   = 20;
   localparam int NUM_SPR = 4;
   localparam int N       = SPR_W * SPR_H;
   localparam int AW      = $clog2(NUM_SPR * N);

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                erase = 1'b0;
   logic [1:0]          sprite_id = 2'd0;
   logic [X_W-1:0]      base_x = '0;
   logic [Y_W-1:0]      base_y = '0;
   logic [COLOUR_W-1:0] bg_colour = '0;
   logic [AW-1:0]       rom_addr;
   logic [COLOUR_W-1:0] rom_q = '0;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                done;

   logic [COLOUR_W-1:0] rom [NUM_SPR*N];

   int checks = 0;
   int errors = 0;
   int bad;

   typedef struct {
      int sid; int bx; int by; int er; int bg;
      int fa;                 // expected first rom_addr
      int plots;              // expected number of plots
      int fx; int fy; int fc; // first plot x, y, cycle (-1 if none)
      int lx; int ly; int lc; // last plot x, y, cycle
      int dc;                 // done cycle
   } vec_t;

   vec_t vecs[6];

   draw_sprite #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .NUM_SPR (NUM_SPR)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .abort     (abort),
      .erase     (erase),
      .sprite_id (sprite_id),
      .base_x    (base_x),
      .base_y    (base_y),
      .bg_colour (bg_colour),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // synchronous sprite ROM
   always @(posedge clk) rom_q <= rom[rom_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rom_addr"}, int'(rom_addr), 0);
      check({tag, "_x"}, int'(x), 0);
      check({tag, "_y"}, int'(y), 0);
      check({tag, "_colour"}, int'(colour), 0);
      check({tag, "_plot"}, int'(plot), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   task automatic load_inputs(input vec_t v);
      sprite_id = 2'(v.sid);
      base_x    = X_W'(v.bx);
      base_y    = Y_W'(v.by);
      erase     = (v.er != 0);
      bg_colour = COLOUR_W'(v.bg);
   endtask

   // Drive one blit from idle and check it cycle by cycle against the model.
   task automatic run_blit(input vec_t v, input string tag);
      int plots = 0, fx = -1, fy = -1, fc = -1, lx = -1, ly = -1, lc = -1;
      int dc = -1, dn = 0, aerr = 0, perr = 0, berr = 0, b1 = 0, a1 = 0, bd = -1;
      int k, ex, ey, ec;
      bit ep;
      @(negedge clk);
      load_inputs(v);
      start = 1'b1;
      for (int c = 1; c <= N + 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) begin
            b1 = int'(busy);
            a1 = int'(rom_addr);
         end
         if (c <= N && int'(rom_addr) != v.fa + c - 1) aerr++;
         if (c <= N + 2 && !busy) berr++;
         k  = c - 3;
         ep = 1'b0;
         ex = 0; ey = 0; ec = 0;
         if (k >= 0 && k < N) begin
            ex = v.bx + k % SPR_W;
            ey = v.by + k / SPR_W;
            ec = (v.er != 0) ? v.bg : int'(rom[v.fa + k]);
            ep = (ex < SCREEN_W) && (ey < SCREEN_H) &&
                 ((v.er != 0) || ec != int'(TRANSPARENT_KEY));
         end
         if (plot != ep) perr++;
         else if (ep && (int'(x) != ex || int'(y) != ey || int'(colour) != ec)) perr++;
         if (plot) begin
            plots++;
            if (fc < 0) begin fx = int'(x); fy = int'(y); fc = c; end
            lx = int'(x); ly = int'(y); lc = c;
         end
         if (done) begin
            dn++;
            if (dc < 0) begin dc = c; bd = int'(busy); end
         end
      end
      check({tag, "_busy_c1"}, b1, 1);
      check({tag, "_addr_c1"}, a1, v.fa);
      check({tag, "_addr_seq_errs"}, aerr, 0);
      check({tag, "_busy_errs"}, berr, 0);
      check({tag, "_pixel_errs"}, perr, 0);
      check({tag, "_plots"}, plots, v.plots);
      check({tag, "_first_x"}, fx, v.fx);
      check({tag, "_first_y"}, fy, v.fy);
      check({tag, "_first_cyc"}, fc, v.fc);
      check({tag, "_last_x"}, lx, v.lx);
      check({tag, "_last_y"}, ly, v.ly);
      check({tag, "_last_cyc"}, lc, v.lc);
      check({tag, "_done_cyc"}, dc, v.dc);
      check({tag, "_done_cnt"}, dn, 1);
      check({tag, "_busy_at_done"}, bd, 0);
   endtask

   initial begin
      //          sid bx   by   er bg     fa    plots fx   fy   fc  lx   ly   lc   dc
      vecs[0] = '{1,  10,  5,   0, 0,     400,  400,  10,  5,   3,  29,  24,  402, 403};
      vecs[1] = '{0,  0,   0,   0, 0,     0,    399,  1,   0,   4,  19,  19,  402, 403};
      vecs[2] = '{0,  0,   0,   1, 'h0AB, 0,    400,  0,   0,   3,  19,  19,  402, 403};
      vecs[3] = '{2,  150, 110, 0, 0,     800,  100,  150, 110, 3,  159, 119, 192, 403};
      vecs[4] = '{3,  140, 100, 1, 'h155, 1200, 400,  140, 100, 3,  159, 119, 402, 403};
      vecs[5] = '{1,  250, 0,   0, 0,     400,  0,    -1,  -1,  -1, -1,  -1,  -1,  403};

      for (int a = 0; a < NUM_SPR * N; a++) rom[a] = COLOUR_W'((a % 500) + 1);
      rom[0] = TRANSPARENT_KEY;

      // reset state
      @(negedge clk);
      check_zero("reset");
      resetn = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (busy || plot || done) bad++;
      end
      check("idle_quiet", bad, 0);

      for (int i = 0; i < 6; i++) run_blit(vecs[i], $sformatf("v%0d", i));

      // re-start ignored, then abort mid-blit
      @(negedge clk);
      load_inputs(vecs[0]);
      start = 1'b1;
      bad = 0;
      for (int c = 1; c <= 110; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 49) begin
            sprite_id = 2'd3;
            start     = 1'b1;
         end
         if (c == 60) check("hs_restart_ignored_addr", int'(rom_addr), 459);
         if (c == 100) begin
            check("hs_busy_before_abort", int'(busy), 1);
            check("hs_plot_before_abort", int'(plot), 1);
            abort = 1'b1;
         end
         if (c == 101) begin
            abort = 1'b0;
            check("hs_busy_after_abort", int'(busy), 0);
            check("hs_plot_after_abort", int'(plot), 0);
         end
         if (c > 100 && (busy || plot || done)) bad++;
      end
      check("hs_quiet_after_abort", bad, 0);
      run_blit(vecs[0], "post_abort");

      // start and abort together in idle: start wins
      @(negedge clk);
      load_inputs(vecs[0]);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sa_busy", int'(busy), 1);
      check("sa_addr", int'(rom_addr), 400);
      @(negedge clk);
      abort = 1'b0;
      check("sa_aborted_busy", int'(busy), 0);

      // reset in the middle of a blit
      @(negedge clk);
      load_inputs(vecs[3]);
      start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("rst_busy_before", int'(busy), 1);
      resetn = 1'b0;
      #1;
      check_zero("midrst");
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (busy || done || plot) bad++;
      end
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (busy || done || plot) bad++;
      end
      check("midrst_quiet", bad, 0);
      run_blit(vecs[3], "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
